jk_q_monitor: RTL and testbench



---
 rtl/jk_q_monitor.sv | 178 +++++++++++++++++
 tb/tb_jk_q_monitor.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_q_monitor.sv
`default_nettype none
// ============================================================================
// Module   : jk_q_monitor
// Purpose  : Observer for a JK cell: synchronises Q/Q2, detects Q edges,
//            counts toggles, measures Q-high length, checks Q2 settling.
// Revision : 1.0  initial release
// ============================================================================
module jk_q_monitor #(
  parameter int CNT_W  = 8,
  parameter int SETTLE = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             q,
  input  logic             q2,
  input  logic             clr,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             cnt_sat,
  output logic [CNT_W-1:0] hi_len,
  output logic             hi_valid,
  output logic             comp_err,
  output logic             busy
);

  localparam logic [1:0]       c_st_fill     = 2'd0;
  localparam logic [1:0]       c_st_steady   = 2'd1;
  localparam logic [1:0]       c_st_settling = 2'd2;
  localparam logic [CNT_W-1:0] c_cnt_max     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       c_settle      = 4'(SETTLE);

  logic             r_q_meta, r_q_s, r_q2_meta, r_q2_s, r_q_d;
  logic [1:0]       r_state, w_state_next;
  logic             r_fill_done;
  logic [3:0]       r_timer, w_timer_next;
  logic             w_err_set, w_busy;
  logic             w_rise, w_fall, w_edge;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_rise_pulse, r_fall_pulse, r_cnt_sat, r_hi_valid, r_comp_err;
  logic [CNT_W-1:0] r_toggle_cnt, r_hi_len, r_hi_acc;
  logic             r_hi_armed;

  // Two-flop synchronisers; q_d takes the fresh q_s value on FILL exit so a
  // level already present at that point is not mistaken for an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q_meta  <= 1'b0;
      r_q_s     <= 1'b0;
      r_q2_meta <= 1'b0;
      r_q2_s    <= 1'b0;
      r_q_d     <= 1'b0;
    end else begin
      r_q_meta  <= q;
      r_q_s     <= r_q_meta;
      r_q2_meta <= q2;
      r_q2_s    <= r_q2_meta;
      r_q_d     <= (r_state == c_st_fill) ? r_q_meta : r_q_s;
    end
  end

  assign w_rise = (r_state != c_st_fill) &&  r_q_s && !r_q_d;
  assign w_fall = (r_state != c_st_fill) && !r_q_s &&  r_q_d;
  assign w_edge = w_rise || w_fall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= c_st_fill;
      r_fill_done <= 1'b0;
      r_timer     <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_timer <= w_timer_next;
      if (r_state == c_st_fill)
        r_fill_done <= 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_err_set    = 1'b0;
    case (r_state)
      c_st_fill: begin
        if (r_fill_done)
          w_state_next = c_st_steady;
      end
      c_st_steady: begin
        if (w_edge) begin
          w_state_next = c_st_settling;
          w_timer_next = c_settle;
        end else if (r_q2_s == r_q_s) begin
          w_err_set = 1'b1;
        end
      end
      c_st_settling: begin
        // A fresh edge restarts the settling window before any other check.
        if (w_edge) begin
          w_timer_next = c_settle;
        end else if (r_q2_s != r_q_s) begin
          w_state_next = c_st_steady;
        end else if (r_timer == 4'd1) begin
          w_err_set    = 1'b1;
          w_state_next = c_st_steady;
        end else begin
          w_timer_next = r_timer - 4'd1;
        end
      end
      default: w_state_next = c_st_fill;
    endcase
  end

  always_comb begin
    w_busy = (r_state == c_st_settling);
  end

  assign w_cnt_inc = (r_toggle_cnt == c_cnt_max) ? r_toggle_cnt : r_toggle_cnt + c_cnt_one;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rise_pulse <= 1'b0;
      r_fall_pulse <= 1'b0;
      r_toggle_cnt <= '0;
      r_cnt_sat    <= 1'b0;
      r_hi_len     <= '0;
      r_hi_valid   <= 1'b0;
      r_hi_acc     <= '0;
      r_hi_armed   <= 1'b0;
      r_comp_err   <= 1'b0;
    end else begin
      r_rise_pulse <= w_rise;
      r_fall_pulse <= w_fall;

      if (clr) begin
        r_toggle_cnt <= '0;
        r_cnt_sat    <= 1'b0;
      end else if (w_edge) begin
        r_toggle_cnt <= w_cnt_inc;
        if (w_cnt_inc == c_cnt_max)
          r_cnt_sat <= 1'b1;
      end

      // The rise cycle itself counts as the first high cycle.
      if (w_rise)
        r_hi_acc <= c_cnt_one;
      else if (r_q_s && (r_hi_acc != c_cnt_max))
        r_hi_acc <= r_hi_acc + c_cnt_one;

      if (w_rise)
        r_hi_armed <= 1'b1;
      else if (w_fall)
        r_hi_armed <= 1'b0;

      r_hi_valid <= w_fall && r_hi_armed && !clr;
      if (clr)
        r_hi_len <= '0;
      else if (w_fall && r_hi_armed)
        r_hi_len <= r_hi_acc;

      if (clr)
        r_comp_err <= 1'b0;
      else if (w_err_set)
        r_comp_err <= 1'b1;
    end
  end

  assign rise_pulse = r_rise_pulse;
  assign fall_pulse = r_fall_pulse;
  assign toggle_cnt = r_toggle_cnt;
  assign cnt_sat    = r_cnt_sat;
  assign hi_len     = r_hi_len;
  assign hi_valid   = r_hi_valid;
  assign comp_err   = r_comp_err;
  assign busy       = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_jk_q_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_q_monitor
// Purpose  : Directed plus randomised bench for jk_q_monitor with an
//            edge/deadline based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_jk_q_monitor;

  localparam int CNT_W  = 4;
  localparam int SETTLE = 3;
  localparam int MAXV   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic q = 1'b0, q2 = 1'b1, clr = 1'b0;
  logic rise_pulse, fall_pulse, cnt_sat, hi_valid, comp_err, busy;
  logic [CNT_W-1:0] toggle_cnt, hi_len;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  jk_q_monitor #(.CNT_W(CNT_W), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset), .q(q), .q2(q2), .clr(clr),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .toggle_cnt(toggle_cnt),
    .cnt_sat(cnt_sat), .hi_len(hi_len), .hi_valid(hi_valid),
    .comp_err(comp_err), .busy(busy)
  );

  // Reference model: k counts clock edges since reset release; the level seen
  // in the first post-fill cycle is a baseline, later level changes are edges.
  int k, edges, rise_cyc, watch_last;
  bit m_q, s_q, m_q2, s_q2, prev, armed, watching;
  bit e_rise, e_fall, e_sat, e_hv, e_err, e_busy;
  int e_tog, e_hilen;

  function automatic void model_reset();
    k = 0; edges = 0; rise_cyc = 0; watch_last = 0;
    m_q = 0; s_q = 0; m_q2 = 0; s_q2 = 0; prev = 0; armed = 0; watching = 0;
    e_rise = 0; e_fall = 0; e_sat = 0; e_hv = 0; e_err = 0; e_busy = 0;
    e_tog = 0; e_hilen = 0;
  endfunction

  function automatic void model_step();
    bit active, ed, rise, fall, err;
    k++;
    active = (k >= 3);
    ed     = (k >= 4) && (s_q != prev);
    rise   = ed && s_q;
    fall   = ed && !s_q;
    e_rise = rise;
    e_fall = fall;
    if (clr) edges = 0;
    else if (ed && edges < 1000) edges++;
    e_tog = (edges > MAXV) ? MAXV : edges;
    e_sat = (edges >= MAXV);
    e_hv  = fall && armed && !clr;
    if (clr) e_hilen = 0;
    else if (fall && armed) e_hilen = ((k - rise_cyc) > MAXV) ? MAXV : (k - rise_cyc);
    if (rise) begin armed = 1; rise_cyc = k; end
    else if (fall) armed = 0;
    err = 0;
    if (active) begin
      if (watching) begin
        if (ed) watch_last = k + SETTLE;
        else if (s_q2 != s_q) watching = 0;
        else if (k == watch_last) begin err = 1; watching = 0; end
      end else begin
        if (ed) begin watching = 1; watch_last = k + SETTLE; end
        else if (s_q2 == s_q) err = 1;
      end
    end
    if (clr) e_err = 0;
    else if (err) e_err = 1;
    e_busy = watching;
    prev = s_q; s_q = m_q; m_q = q;
    s_q2 = m_q2; m_q2 = q2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("rise_pulse", 32'(rise_pulse), 32'(e_rise));
      chk("fall_pulse", 32'(fall_pulse), 32'(e_fall));
      chk("toggle_cnt", 32'(toggle_cnt), 32'(e_tog));
      chk("cnt_sat",    32'(cnt_sat),    32'(e_sat));
      chk("hi_len",     32'(hi_len),     32'(e_hilen));
      chk("hi_valid",   32'(hi_valid),   32'(e_hv));
      chk("comp_err",   32'(comp_err),   32'(e_err));
      chk("busy",       32'(busy),       32'(e_busy));
    end
  end

  task automatic step();
    @(posedge clk);
    if (reset) model_step();
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asserts reset mid-cycle and checks that outputs drop without a clock.
  task automatic reset_mid(input string tag);
    @(posedge clk);
    model_step();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk({tag, "_async_busy"},  32'(busy), 32'd0);
    chk({tag, "_async_tog"},   32'(toggle_cnt), 32'd0);
    chk({tag, "_async_err"},   32'(comp_err), 32'd0);
    chk({tag, "_async_hilen"}, 32'(hi_len), 32'd0);
    chk({tag, "_async_pulse"}, 32'(rise_pulse | fall_pulse | hi_valid | cnt_sat), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int lag;
    #1 reset = 1'b0;
    model_reset();
    cmp_en = 1'b1;
    steps(3);
    reset = 1'b1;

    // Idle complementary levels
    steps(10);
    chk("idle_err", 32'(comp_err), 32'd0);
    chk("idle_tog", 32'(toggle_cnt), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Clean rise, Q2 following two cycles later
    q = 1'b1;
    steps(2);
    chk("rise_early", 32'(rise_pulse), 32'd0);
    q2 = 1'b0;
    step();
    chk("rise_pulse_lat3", 32'(rise_pulse), 32'd1);
    chk("rise_tog", 32'(toggle_cnt), 32'd1);
    steps(6);
    chk("rise_clean_err", 32'(comp_err), 32'd0);

    // Rise with Q2 stuck high: error exactly SETTLE cycles after entry
    q = 1'b0; q2 = 1'b1;
    steps(6);
    q = 1'b1;
    steps(5);
    chk("stuck_err_before", 32'(comp_err), 32'd0);
    step();
    chk("stuck_err_at", 32'(comp_err), 32'd1);
    q2 = 1'b0;
    steps(5);
    chk("stuck_err_sticky", 32'(comp_err), 32'd1);
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_err", 32'(comp_err), 32'd0);

    // Five-cycle high pulse
    q = 1'b0; q2 = 1'b1;
    steps(6);
    clr = 1'b1; step(); clr = 1'b0;
    q = 1'b1; q2 = 1'b0;
    steps(5);
    q = 1'b0; q2 = 1'b1;
    steps(3);
    chk("pulse_fall", 32'(fall_pulse), 32'd1);
    chk("pulse_hv", 32'(hi_valid), 32'd1);
    chk("pulse_hilen", 32'(hi_len), 32'd5);
    chk("pulse_tog", 32'(toggle_cnt), 32'd2);

    // Saturation, then clr colliding with an edge
    for (int i = 0; i < 20; i++) begin
      q = ~q; q2 = ~q;
      steps(4);
    end
    chk("sat_tog", 32'(toggle_cnt), 32'(MAXV));
    chk("sat_flag", 32'(cnt_sat), 32'd1);
    q = ~q; q2 = ~q;
    steps(2);
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_edge_tog", 32'(toggle_cnt), 32'd0);
    chk("clr_edge_sat", 32'(cnt_sat), 32'd0);
    chk("clr_edge_pulse", 32'(rise_pulse | fall_pulse), 32'd1);
    chk("clr_edge_busy", 32'(busy), 32'd1);

    // Reset while settling
    q = ~q;
    steps(4);
    chk("settling_busy", 32'(busy), 32'd1);
    reset_mid("settle");
    q2 = ~q;
    steps(2);
    reset = 1'b1;
    steps(2);
    chk("post_reset_busy", 32'(busy), 32'd0);
    steps(8);
    chk("post_reset_err", 32'(comp_err), 32'd0);

    // Randomised cell behaviour: Q2 follows Q with a random lag, plus glitches
    lag = -1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        q = ~q;
        lag = int'($urandom_range(0, 5));
      end
      if (lag == 0) begin
        q2 = ~q;
        lag = -1;
      end else if (lag > 0) begin
        lag--;
      end
      if ($urandom_range(0, 39) == 0) q2 = ~q2;
      clr = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 799) == 0) begin
        reset_mid("rand");
        steps(2);
        reset = 1'b1;
      end
      step();
    end
    clr = 1'b0;
    cmp_en = 1'b0;
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
